// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
// Command-decoding single-port RAM placed directly behind an SPI slave.
// Each valid command word selects one of four operations:
//   00 WR_ADDR  load write address (range-checked against MEM_DEPTH)
//   01 WR_DATA  write payload to mem[wr_addr] (needs a loaded write address)
//   10 RD_ADDR  load read address (range-checked against MEM_DEPTH)
//   11 RD_DATA  latch mem[rd_addr] onto dout and open an ADDR_SIZE-cycle
//               tx_valid window (needs a loaded read address, IDLE only)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   [ADDR_SIZE+1:0] command word: opcode in the top two bits,
//                  payload in the low ADDR_SIZE bits
//   rx_valid  in   din valid, one command per high cycle
//   dout      out  [ADDR_SIZE-1:0] read byte for the SPI slave tx_data
//   tx_valid  out  high for ADDR_SIZE cycles after an accepted RD_DATA
//   err       out  one-cycle pulse for every rejected command
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 err
);

    localparam int                   CNT_W     = $clog2(ADDR_SIZE + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(ADDR_SIZE - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_ok;
    logic                 rd_ok;

    op_t                  op;
    logic [ADDR_SIZE-1:0] payload;
    logic                 in_range;
    logic                 wr_addr_load;
    logic                 wr_data_go;
    logic                 rd_addr_load;
    logic                 rd_accept;
    logic                 reject;

    assign op       = op_t'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload  = din[ADDR_SIZE-1:0];
    // Zero-extend by one bit so MEM_DEPTH == 2**ADDR_SIZE stays representable.
    assign in_range = ({1'b0, payload} < DEPTH);

    // Post-increment with wrap at MEM_DEPTH (not at 2**ADDR_SIZE).
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (AUTO_INC == 0) begin
            return a;
        end
        return (a == ADDR_LAST) ? '0 : a + 1'b1;
    endfunction

    // Command decode: exactly one of the action strobes or reject per command.
    always_comb begin
        wr_addr_load = 1'b0;
        wr_data_go   = 1'b0;
        rd_addr_load = 1'b0;
        rd_accept    = 1'b0;
        reject       = 1'b0;
        if (rx_valid) begin
            case (op)
                OP_WR_ADDR: if (in_range) wr_addr_load = 1'b1; else reject = 1'b1;
                OP_WR_DATA: if (wr_ok)    wr_data_go   = 1'b1; else reject = 1'b1;
                OP_RD_ADDR: if (in_range) rd_addr_load = 1'b1; else reject = 1'b1;
                OP_RD_DATA: if (state == IDLE && rd_ok) rd_accept = 1'b1;
                            else reject = 1'b1;
                default:    reject = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_accept) state_next = SEND;
            SEND:    if (cnt == CNT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded straight from the state register so an asynchronous reset
    // drops the window immediately.
    assign tx_valid = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            wr_ok   <= 1'b0;
            rd_ok   <= 1'b0;
            dout    <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            err   <= reject;

            if (state == SEND) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end

            if (wr_addr_load) begin
                wr_addr <= payload;
                wr_ok   <= 1'b1;
            end else if (wr_data_go) begin
                wr_addr <= next_addr(wr_addr);
            end

            if (rd_addr_load) begin
                rd_addr <= payload;
                rd_ok   <= 1'b1;
            end else if (rd_accept) begin
                dout    <= mem[rd_addr];
                rd_addr <= next_addr(rd_addr);
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_data_go) begin
            mem[wr_addr] <= payload;
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Testbench for spi_ram_ctrl. Three instances cover the default build,
// a reduced MEM_DEPTH build and an AUTO_INC build. A driver issues commands
// and pushes expected err flags and read bytes into per-instance queues; a
// monitor pops and compares whenever the DUT answers.
module tb_spi_ram_ctrl;

    localparam logic [1:0] WA  = 2'b00;
    localparam logic [1:0] WD  = 2'b01;
    localparam logic [1:0] RA  = 2'b10;
    localparam logic [1:0] RDD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rxv    [3];
    logic [7:0] dout_w [3];
    logic       tx_w   [3];
    logic       err_w  [3];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[0]),
        .dout(dout_w[0]), .tx_valid(tx_w[0]), .err(err_w[0]));

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[1]),
        .dout(dout_w[1]), .tx_valid(tx_w[1]), .err(err_w[1]));

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[2]),
        .dout(dout_w[2]), .tx_valid(tx_w[2]), .err(err_w[2]));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q [3][$];
    bit         err_q [3][$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One command held for one cycle; expectations queued before the
    // sampling edge so the monitor always finds them.
    task automatic cmd(input int i, input logic [1:0] op, input logic [7:0] pl,
                       input bit e, input bit push, input logic [7:0] byte_exp);
        @(negedge clk);
        din    = {op, pl};
        rxv[i] = 1'b1;
        err_q[i].push_back(e);
        if (push) exp_q[i].push_back(byte_exp);
        @(negedge clk);
        rxv[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    bit         issued  [3];
    bit         tx_prev [3];
    int         run     [3];
    logic [7:0] held    [3];
    bit         changed [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) issued[i] = rxv[i] && rst_n;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                tx_prev[k] = 1'b0;
                run[k]     = 0;
                changed[k] = 1'b0;
            end else begin
                if (issued[k]) begin
                    if (err_q[k].size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL err_queue%0d: command seen with no expectation", k);
                    end else begin
                        check($sformatf("err%0d", k), int'(err_w[k]), int'(err_q[k].pop_front()));
                    end
                end else if (err_w[k]) begin
                    n_cmp++; n_bad++;
                    $display("FAIL err_spurious%0d: got 1, expected 0 (t=%0t)", k, $time);
                end

                if (tx_w[k] && !tx_prev[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_unexpected%0d: tx_valid rose, expected no read (t=%0t)", k, $time);
                    end else begin
                        check($sformatf("rd_byte%0d", k), int'(dout_w[k]), int'(exp_q[k].pop_front()));
                    end
                    held[k]    = dout_w[k];
                    changed[k] = 1'b0;
                    run[k]     = 1;
                end else if (tx_w[k]) begin
                    run[k]++;
                    if (dout_w[k] != held[k]) changed[k] = 1'b1;
                end else if (tx_prev[k]) begin
                    check($sformatf("tx_width%0d", k), run[k], 8);
                    check($sformatf("dout_hold%0d", k), int'(changed[k]), 0);
                    check($sformatf("dout_after%0d", k), int'(dout_w[k]), int'(held[k]));
                    run[k] = 0;
                end
                tx_prev[k] = tx_w[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        din   = '0;
        for (int i = 0; i < 3; i++) rxv[i] = 1'b0;
        idle(3);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_dout%0d", i), int'(dout_w[i]), 0);
            check($sformatf("rst_tx%0d", i),   int'(tx_w[i]),   0);
            check($sformatf("rst_err%0d", i),  int'(err_w[i]),  0);
        end

        // Seed mem[0] = 0xC3, then reset: memory must survive it.
        cmd(0, WA, 8'h00, 0, 0, 8'h00);
        cmd(0, WD, 8'hC3, 0, 0, 8'h00);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Rejects right after reset: no address loaded yet.
        cmd(0, RDD, 8'h00, 1, 0, 8'h00);
        cmd(0, WD,  8'h55, 1, 0, 8'h00);
        cmd(0, RA,  8'h00, 0, 0, 8'h00);
        cmd(0, RDD, 8'h00, 0, 1, 8'hC3);
        idle(10);

        // Basic write / read.
        cmd(0, WA,  8'h3C, 0, 0, 8'h00);
        cmd(0, WD,  8'hA5, 0, 0, 8'h00);
        cmd(0, RA,  8'h3C, 0, 0, 8'h00);
        cmd(0, RDD, 8'h00, 0, 1, 8'hA5);
        idle(10);

        // Traffic during SEND: second read rejected, write does not touch dout.
        cmd(0, RA,  8'h3C, 0, 0, 8'h00);
        cmd(0, RDD, 8'h00, 0, 1, 8'hA5);
        cmd(0, RDD, 8'h00, 1, 0, 8'h00);
        cmd(0, WD,  8'hEE, 0, 0, 8'h00);
        idle(10);
        cmd(0, RDD, 8'h00, 0, 1, 8'hEE);
        idle(10);

        // Reset in the middle of a window.
        cmd(0, RDD, 8'h00, 0, 1, 8'hEE);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx",   int'(tx_w[0]),   0);
        check("midrst_dout", int'(dout_w[0]), 0);
        idle(2);
        rst_n = 1'b1;

        // MEM_DEPTH = 200: out-of-range addresses rejected, registers kept.
        cmd(1, WA,  8'h10, 0, 0, 8'h00);
        cmd(1, WA,  8'hF0, 1, 0, 8'h00);
        cmd(1, WD,  8'h77, 0, 0, 8'h00);
        cmd(1, RA,  8'h10, 0, 0, 8'h00);
        cmd(1, RA,  8'hC8, 1, 0, 8'h00);
        cmd(1, RDD, 8'h00, 0, 1, 8'h77);
        idle(10);

        // AUTO_INC = 1: address wraps 0xFF -> 0x00.
        cmd(2, WA,  8'hFF, 0, 0, 8'h00);
        cmd(2, WD,  8'h11, 0, 0, 8'h00);
        cmd(2, WD,  8'h22, 0, 0, 8'h00);
        cmd(2, RA,  8'hFF, 0, 0, 8'h00);
        cmd(2, RDD, 8'h00, 0, 1, 8'h11);
        idle(10);
        cmd(2, RDD, 8'h00, 0, 1, 8'h22);
        idle(10);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("pending_rd%0d", i),  exp_q[i].size(), 0);
            check($sformatf("pending_err%0d", i), err_q[i].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
